// File: rtl/bus_mem_slave.sv
// Word RAM bus responder with programmable wait states between capture and ack.
// Latency: request captured at edge E0 acks in cycle E0+1+WAIT_CYCLES (1-cycle o_ack pulse).
// Backpressure: one transaction in flight; requests are only sampled in IDLE, master holds i_bus_en until o_ack.
module bus_mem_slave #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_byte_en,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic        o_err,
    output logic        o_busy
);

    localparam int          AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
    // Byte span covered by the RAM; (offset >> 2) < MEM_WORDS is the same test as offset < span.
    localparam logic [32:0] SPAN_BYTES = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Transaction captured in IDLE and held through WAIT
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic [3:0]  be_q;

    // Effective transaction: live bus inputs on the capture edge, latched copy afterwards.
    // With zero wait states the capture edge is also the edge entering ACK.
    logic        cur_wr;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdat;
    logic [3:0]  cur_be;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        capture;
    logic        enter_ack;

    logic [31:0] mem [MEM_WORDS];

    // Select the transaction fields and decode address range
    always_comb begin
        cur_wr   = wr_q;
        cur_addr = addr_q;
        cur_wdat = wdat_q;
        cur_be   = be_q;
        if (state == ST_IDLE) begin
            cur_wr   = i_wr_en;
            cur_addr = i_addr;
            cur_wdat = i_wr_data;
            cur_be   = i_byte_en;
        end
        offset   = cur_addr - BASE_ADDR;
        in_range = ({1'b0, offset} < SPAN_BYTES);
        idx      = offset[AW+1:2];
    end

    assign capture   = (state == ST_IDLE) && i_bus_en;
    assign enter_ack = (capture && (WAIT_CYCLES == 0)) ||
                       ((state == ST_WAIT) && (cnt == 4'd1));

    // RAM write port: commits byte lanes on the edge entering ACK; a reset on that edge drops the write
    always_ff @(posedge i_clk) begin
        if (i_rst && enter_ack && cur_wr && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[idx][8*b +: 8] <= cur_wdat[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered ack/err/read-data/busy outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdat_q    <= 32'd0;
            be_q      <= 4'd0;
            o_ack     <= 1'b0;
            o_err     <= 1'b0;
            o_rd_data <= 32'd0;
            o_busy    <= 1'b0;
        end else begin
            o_ack     <= 1'b0;
            o_err     <= 1'b0;
            o_rd_data <= 32'd0;
            if (enter_ack) begin
                o_ack <= 1'b1;
                o_err <= !in_range;
                if (!cur_wr) begin
                    o_rd_data <= in_range ? mem[idx] : ERR_DATA;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (i_bus_en) begin
                        wr_q   <= i_wr_en;
                        addr_q <= i_addr;
                        wdat_q <= i_wr_data;
                        be_q   <= i_byte_en;
                        cnt    <= WAIT_INIT;
                        o_busy <= 1'b1;
                        state  <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
